// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte request and serial line bundle for uart_tx.
//   P_DATA     [7:0] byte to transmit
//   Data_Valid       one-cycle send request
//   PAR_EN           1 = parity bit inserted
//   PAR_TYP          0 = even, 1 = odd parity
//   prescale   [5:0] CLK cycles per serial bit (0 behaves as 1)
//   TX_OUT           serial line, idle high
//   busy             frame in progress, requests ignored while high
// master: request source; slave: the transmitter.
interface uart_tx_if;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- serial transmitter: start bit, 8 data bits LSB first,
// optional parity bit, stop bit; each bit lasts the latched prescale.
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   bus  uart_tx_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale
//        in; TX_OUT, busy out)
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state;
// without it PAR_EN/PAR_TYP are ignored and every frame is 10 bits.
module uart_tx (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q;
  logic [5:0] presc_q;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       latch;
  logic [5:0] period_last;
  logic       bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
`else
  logic unused_par;
  assign unused_par = ^{bus.PAR_EN, bus.PAR_TYP};
`endif

  // A prescale of 0 is stretched to a one-cycle bit.
  assign period_last = (presc_q == 6'd0) ? 6'd0 : presc_q - 6'd1;
  assign bit_end     = (cnt_q == period_last);

  // Outputs are computed one cycle ahead and registered, so the start bit
  // appears on the edge that accepts the request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (bus.Data_Valid) begin
          latch   = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        if (!bit_end) begin
          cnt_d = cnt_q + 6'd1;
        end else begin
          cnt_d = '0;
          case (state_q)
            START: begin
              state_d = DATA;
              idx_d   = '0;
              tx_d    = data_q[0];
            end
            DATA: begin
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                if (par_en_q) begin
                  state_d = PARITY;
                  tx_d    = (^data_q) ^ par_typ_q;
                end else begin
                  state_d = STOP;
                  tx_d    = 1'b1;
                end
`else
                state_d = STOP;
                tx_d    = 1'b1;
`endif
              end else begin
                tx_d = data_q[idx_d];
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`endif
            STOP: begin
              state_d = IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
            default: begin
              state_d = IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      presc_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (latch) begin
        data_q    <= bus.P_DATA;
        presc_q   <= bus.prescale;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
`endif
      end
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx. Expected frames are built
// as a list of line levels (start, data LSB first, optional parity, stop),
// each repeated for the effective prescale, and compared cycle by cycle.
module tb_uart_tx;

  logic CLK_tb = 1'b0;
  logic rst_tb;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  uart_tx_if u_if ();

  uart_tx dut (
    .CLK (CLK_tb),
    .RST (rst_tb),
    .bus (u_if)
  );

  always #5 CLK_tb = ~CLK_tb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: list of bit levels and bit period.
  task automatic build_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic [5:0] presc, output logic bits[$], output int p);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    if (pen) bits.push_back((^d) ^ ptyp);
`else
    if (pen || ptyp) begin end
`endif
    bits.push_back(1'b1);
    p = (presc == 6'd0) ? 1 : int'(presc);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tx"}, 32'(u_if.TX_OUT), 32'd1);
    chk({tag, "_busy"}, 32'(u_if.busy), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; presents the request, checks the
  // whole frame, and returns at the negedge of the first idle cycle after it.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic [5:0] presc,
                           input bit hold, input bit corrupt);
    logic bits[$];
    int   p;
    int   busy_cnt;
    build_frame(d, pen, ptyp, presc, bits, p);
    u_if.P_DATA     = d;
    u_if.PAR_EN     = pen;
    u_if.PAR_TYP    = ptyp;
    u_if.prescale   = presc;
    u_if.Data_Valid = 1'b1;
    @(negedge CLK_tb);
    if (!hold) u_if.Data_Valid = 1'b0;
    busy_cnt = 0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < p; c++) begin
        chk($sformatf("%s_bit%0d_tx", tag, b), 32'(u_if.TX_OUT), 32'(bits[b]));
        if (u_if.busy === 1'b1) busy_cnt++;
        if (corrupt && b == 2 && c == 0) begin
          u_if.P_DATA   = 8'h00;
          u_if.PAR_EN   = ~pen;
          u_if.PAR_TYP  = ~ptyp;
          u_if.prescale = presc + 6'd3;
        end
        @(negedge CLK_tb);
      end
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(bits.size() * p));
    check_idle({tag, "_end"});
  endtask

  initial begin
    logic bits[$];
    int   p;
    logic [7:0] rd;
    logic [5:0] rp;

    rst_tb          = 1'b1;
    u_if.P_DATA     = 8'h00;
    u_if.Data_Valid = 1'b0;
    u_if.PAR_EN     = 1'b0;
    u_if.PAR_TYP    = 1'b0;
    u_if.prescale   = 6'd0;
    repeat (3) @(negedge CLK_tb);
    check_idle("reset");
    rst_tb = 1'b0;
    @(negedge CLK_tb);
    check_idle("post_reset");

    run_frame("ab_nopar", 8'hAB, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
    run_frame("ab_even",  8'hAB, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
    run_frame("ab_odd",   8'hAB, 1'b1, 1'b1, 6'd8, 1'b0, 1'b1);
    run_frame("ff_p0",    8'hFF, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);

    // Data_Valid held high: exactly one idle cycle between frames.
    run_frame("b2b_1", 8'h55, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0);
    run_frame("b2b_2", 8'h55, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0);
    u_if.Data_Valid = 1'b0;
    repeat (5) begin
      @(negedge CLK_tb);
      check_idle("b2b_noqueue");
    end

    // Reset during data bit 3.
    build_frame(8'hC6, 1'b0, 1'b0, 6'd8, bits, p);
    u_if.P_DATA     = 8'hC6;
    u_if.PAR_EN     = 1'b0;
    u_if.prescale   = 6'd8;
    u_if.Data_Valid = 1'b1;
    @(negedge CLK_tb);
    u_if.Data_Valid = 1'b0;
    for (int k = 0; k < 4 * p + 3; k++) begin
      chk("rst_pre_tx", 32'(u_if.TX_OUT), 32'(bits[k / p]));
      chk("rst_pre_busy", 32'(u_if.busy), 32'd1);
      @(negedge CLK_tb);
    end
    rst_tb = 1'b1;
    @(negedge CLK_tb);
    check_idle("rst_abort");
    rst_tb = 1'b0;
    repeat (30) begin
      @(negedge CLK_tb);
      check_idle("rst_stay_idle");
    end

    // Reset wins over a same-edge request.
    rst_tb          = 1'b1;
    u_if.Data_Valid = 1'b1;
    @(negedge CLK_tb);
    check_idle("rst_prio");
    rst_tb          = 1'b0;
    u_if.Data_Valid = 1'b0;
    @(negedge CLK_tb);
    check_idle("rst_prio_after");

    for (int n = 0; n < 8; n++) begin
      rd = 8'($urandom);
      rp = 6'($urandom_range(0, 6));
      run_frame($sformatf("rand%0d", n), rd, 1'($urandom), 1'($urandom), rp,
                1'b0, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK_tb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK  input  1  rising-edge clock; RST  input  1  synchronous active-high reset.
REQ-002 The block SHALL have port P_DATA  input  8  parallel byte to transmit.
REQ-003 The block SHALL have port Data_Valid  input  1  request to send P_DATA, one-cycle qualifier.
REQ-004 The block SHALL have port PAR_EN  input  1  parity bit enable, 1 = parity bit inserted.
REQ-005 The block SHALL have port PAR_TYP  input  1  parity type, 0 = even, 1 = odd.
REQ-006 The block SHALL have port prescale  input  6  CLK cycles per serial bit.
REQ-007 The block SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-008 The block SHALL have port busy  output  1  frame in progress; new requests are ignored while high.

Function
REQ-009 The block SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-010 In IDLE, the block SHALL drive TX_OUT=1 and busy=0.
REQ-011 The block SHALL accept a request only on a clock edge where state=IDLE and Data_Valid=1.
REQ-012 On acceptance, the block SHALL latch P_DATA, PAR_EN, PAR_TYP and prescale, and SHALL ignore later changes to these inputs until the next acceptance.
REQ-013 On the cycle after acceptance, the block SHALL enter START with TX_OUT=0 and busy=1; the latency from the accepting edge to the first start-bit cycle SHALL be 1 cycle.
REQ-014 Each bit (start, data, parity, stop) SHALL be held on TX_OUT for exactly latched-prescale cycles, timed by a bit-period counter.
REQ-015 A latched prescale of 0 SHALL be treated as 1.
REQ-016 The DATA state SHALL send 8 bits LSB first, using a 3-bit index that wraps 7->0 on leaving DATA.
REQ-017 From DATA, the next state SHALL be PARITY if latched PAR_EN=1, otherwise STOP.
REQ-018 The PARITY bit SHALL equal the XOR of the 8 data bits when PAR_TYP=0, and its inverse when PAR_TYP=1.
REQ-019 STOP SHALL drive TX_OUT=1 for prescale cycles and then return to IDLE.
REQ-020 busy SHALL be high for exactly (10 or 11) x prescale cycles, aligned with the frame on TX_OUT.
REQ-021 Data_Valid asserted while busy=1, including the final stop cycle, SHALL be dropped with no buffering.
REQ-022 A request accepted in the first IDLE cycle after a stop bit SHALL produce back-to-back frames with no idle gap beyond that single cycle.
REQ-023 TX_OUT and busy SHALL be registered outputs with no combinational path from any input.

Reset
REQ-024 On any edge with RST=1, the block SHALL enter IDLE, set TX_OUT=1 and busy=0, and clear the counter, the bit index and all latched registers.
REQ-025 A reset asserted mid-frame SHALL abort the frame with TX_OUT=1 on the next edge, and no partial frame SHALL resume after RST falls.
REQ-026 RST SHALL take priority over Data_Valid on the same edge.

Configuration
REQ-027 The parity feature SHALL be compiled in by macro UART_TX_PARITY_EN.
REQ-028 With UART_TX_PARITY_EN defined, the PARITY state and parity logic SHALL exist and follow REQ-017 and REQ-018.
REQ-029 Without UART_TX_PARITY_EN, the PAR_EN and PAR_TYP ports SHALL remain present but be ignored, the PARITY state SHALL not exist, every frame SHALL be 10 bits, and busy SHALL last 10 x prescale cycles.

Verification
REQ-030 The bench SHALL cover: prescale=8, PAR_EN=0, P_DATA=0xAB, one-cycle Data_Valid -> TX_OUT 0,1,1,0,1,0,1,0,1,1, each held 8 cycles; busy high 80 cycles.
REQ-031 The bench SHALL cover: prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xAB -> parity bit 1, 11-bit frame, busy high 88 cycles.
REQ-032 The bench SHALL cover: prescale=8, PAR_EN=1, PAR_TYP=1, P_DATA=0xAB -> parity bit 0; changing P_DATA to 0x00 during the frame has no effect.
REQ-033 The bench SHALL cover: Data_Valid=1 held continuously, prescale=4, P_DATA=0x55 -> successive frames separated by exactly 1 idle cycle; requests during busy are not queued.
REQ-034 The bench SHALL cover: RST=1 pulsed during data bit 3 of a frame -> next edge TX_OUT=1 and busy=0; with no new request, the line stays idle.
REQ-035 The bench SHALL cover: prescale=0, P_DATA=0xFF, PAR_EN=0 -> every bit lasts 1 cycle; busy high 10 cycles.
